// File: rtl/inst_fetch_pkg.sv
// Types and helpers shared by the instruction fetch unit, its FIFO wrapper
// and the instruction memory interface. Widths come from common.vh.
package inst_fetch_pkg;
`include "common.vh"

  typedef logic [`WORD-1:0]      word_t;
  typedef logic [`INST_SIZE-1:0] inst_t;

  // One fetch buffer entry: the instruction together with the PC it came from.
  typedef struct packed {
    word_t pc;
    inst_t inst;
  } fetch_entry_t;

  localparam word_t PcIncr = word_t'(`PC_INCR);

  // Sequential successor of a PC; wraps modulo 2^WORD.
  function automatic word_t pc_advance(input word_t pc);
    return pc + PcIncr;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bus.
//   imem_req    : request valid (fetch -> memory)
//   imem_addr   : request byte address
//   imem_ready  : request accepted when imem_req && imem_ready
//   imem_rvalid : in-order response valid, at least one cycle after accept
//   imem_rdata  : response instruction
// master = fetch unit side, slave = memory side.
interface inst_fetch_if import inst_fetch_pkg::*; ();
  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  logic  imem_rvalid;
  inst_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/common.vh
// Shared machine-width definitions for the fetch slice.
//   WORD      : address / PC width in bits
//   INST_SIZE : instruction width in bits
//   PC_INCR   : byte step between sequential instructions
`ifndef COMMON_VH
`define COMMON_VH
`define WORD      64
`define INST_SIZE 32
`define PC_INCR   4
`endif

// File: rtl/fetch_fifo.sv
// Small circular FIFO used as the fetch buffer.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data at the tail
//   pop       : drop the head entry (ignored when empty)
//   flush     : empty the FIFO; wins over push and pop in the same cycle
//   head      : head entry, zero while empty
//   count     : current occupancy 0..DEPTH
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    count = count_q;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential instruction requests, buffers
// in-order responses with their PCs and presents the head to decode.
//   clk, rst    : clock, synchronous active-high reset
//   imem        : instruction memory bus (master side)
//   br_taken    : redirect from execute; br_target is the new PC
//   if_valid    : head entry valid; if_inst / if_pc carry it
//   id_ready    : decode consumes the head when if_valid && id_ready
//   if_misalign : sticky misaligned-redirect flag (only with IF_MISALIGN_CHK_EN)
// Optional feature macro: IF_MISALIGN_CHK_EN.
module inst_fetch import inst_fetch_pkg::*; #(
  parameter word_t       RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master imem,
  input  logic         br_taken,
  input  word_t        br_target,
  output logic         if_valid,
  output inst_t        if_inst,
  output word_t        if_pc,
  input  logic         id_ready
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic         if_misalign
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DepthLim = (CW + 1)'(DEPTH);

  // pc_q is the next request address; rsp_pc_q is the PC of the next
  // response that will be kept (responses are in order, so it just counts).
  word_t         pc_q, pc_d;
  word_t         rsp_pc_q, rsp_pc_d;
  // live_q: outstanding requests whose responses will be kept.
  // disc_q: outstanding requests made stale by a redirect or reset.
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] in_flight, in_flight_left;
  logic [CW-1:0] occ;
  logic [CW:0]   budget;
  logic          block_req;
  logic          req, accept, ret, keep, pop;
  fetch_entry_t  push_entry, head_entry;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (br_taken && (br_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign block_req   = misalign_q;
  assign if_misalign = misalign_q;
`else
  assign block_req = 1'b0;
`endif

  always_comb begin
    in_flight      = live_q + disc_q;
    // Everything still in flight after this cycle's return; used when
    // a redirect or reset turns all of it stale.
    in_flight_left = in_flight - CW'(ret && (in_flight != '0));
    budget         = {1'b0, occ} + {1'b0, in_flight};
    req            = !rst && !br_taken && !block_req && (budget < DepthLim);
    accept         = req && imem.imem_ready;
    ret            = imem.imem_rvalid;
    keep           = ret && !rst && !br_taken && (disc_q == '0);
    pop            = if_valid && id_ready;
  end

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    live_d   = live_q;
    disc_d   = disc_q;
    if (accept) begin
      pc_d   = pc_advance(pc_q);
      live_d = live_q + CW'(1);
    end
    // Stale responses always come first, so they drain disc_q before live_q.
    if (ret) begin
      if (disc_q != '0) begin
        disc_d = disc_q - CW'(1);
      end else if (live_d != '0) begin
        live_d = live_d - CW'(1);
      end
    end
    if (keep) rsp_pc_d = pc_advance(rsp_pc_q);
    if (br_taken) begin
      pc_d     = br_target;
      rsp_pc_d = br_target;
      live_d   = '0;
      disc_d   = in_flight_left;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      live_q   <= '0;
      // Abandoned requests still answer; their responses must be dropped.
      disc_q   <= in_flight_left;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      live_q   <= live_d;
      disc_q   <= disc_d;
    end
  end

  assign push_entry = '{pc: rsp_pc_q, inst: imem.imem_rdata};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (keep),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (br_taken),
    .head     (head_entry),
    .count    (occ)
  );

  assign if_valid       = (occ != '0);
  assign if_inst        = head_entry.inst;
  assign if_pc          = head_entry.pc;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  localparam int          Depth   = 2;
  localparam logic [63:0] ResetPc = 64'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [63:0] br_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        id_ready;
`ifdef IF_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  inst_fetch_if imem_bus ();

  inst_fetch #(
    .RESET_PC(ResetPc),
    .DEPTH   (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .imem     (imem_bus),
    .br_taken (br_taken),
    .br_target(br_target),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .id_ready (id_ready)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Model: memory returns inst_of(addr); pending requests carry the epoch
  // they were issued in; mq is the expected decode-side buffer.
  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] mq[$];
  logic [63:0] acc_log[$];
  logic [63:0] pop_log[$];
  int          epoch, cyc;
  logic [63:0] exp_pc;
  bit          mis;
  bit          have_last;
  logic [63:0] last_pop;
  int          lat_min, lat_max, rdy_pct, idr_pct;
  int          checks, failures;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5EED_0013;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] log_at(input bit use_pop, input int n);
    if (use_pop) return (pop_log.size() > n) ? pop_log[n] : 64'hDEAD_DEAD_DEAD_DEAD;
    return (acc_log.size() > n) ? acc_log[n] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // One clock: drive at negedge, compare #1 later, then advance the model
  // with the events the posedge will see.
  task automatic cycle(input bit do_br, input logic [63:0] tgt, input bit do_rst);
    bit    exp_req, acc, pop, fresh;
    pend_t r;
    int    due;
    @(negedge clk);
    rst       = do_rst;
    br_taken  = do_br;
    br_target = tgt;
    id_ready  = ($urandom_range(99) < idr_pct);
    imem_bus.imem_ready = ($urandom_range(99) < rdy_pct);
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = inst_of(pend[0].addr);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = $urandom;
    end
    #1;
    exp_req = !do_rst && !do_br && !mis && ((mq.size() + pend.size()) < Depth);
    check64("imem_req", {63'd0, imem_bus.imem_req}, {63'd0, exp_req});
    if (exp_req) check64("imem_addr", imem_bus.imem_addr, exp_pc);
    check64("if_valid", {63'd0, if_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check64("if_pc", if_pc, mq[0]);
      check64("if_inst", {32'd0, if_inst}, {32'd0, inst_of(mq[0])});
    end
`ifdef IF_MISALIGN_CHK_EN
    check64("if_misalign", {63'd0, if_misalign}, {63'd0, mis});
`endif
    acc   = exp_req && imem_bus.imem_ready;
    pop   = (mq.size() != 0) && id_ready;
    fresh = 1'b0;
    if (imem_bus.imem_rvalid) begin
      r     = pend.pop_front();
      fresh = (r.epoch == epoch) && !do_br && !do_rst;
    end
    if (pop) begin
      if (have_last) check64("pc_seq", if_pc, last_pop + 64'd4);
      have_last = 1'b1;
      last_pop  = mq[0];
      pop_log.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (fresh) mq.push_back(r.addr);
    if (acc) begin
      acc_log.push_back(exp_pc);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (pend.size() != 0 && due <= pend[$].due) due = pend[$].due + 1;
      pend.push_back('{addr: exp_pc, epoch: epoch, due: due});
      exp_pc = exp_pc + 64'd4;
    end
    check64("no_overflow", {32'd0, mq.size()} <= Depth, 64'd1);
    if (do_br) begin
      mq.delete();
      exp_pc    = tgt;
      epoch++;
      have_last = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) mis = 1'b1;
`endif
    end
    if (do_rst) begin
      mq.delete();
      exp_pc    = ResetPc;
      epoch++;
      have_last = 1'b0;
      mis       = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    int n;
    bit hit;
    rst = 1'b1; br_taken = 1'b0; br_target = '0; id_ready = 1'b1;
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    epoch = 0; cyc = 0; exp_pc = ResetPc; mis = 1'b0; have_last = 1'b0; last_pop = '0;
    lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 100;
    checks = 0; failures = 0;

    // Reset state
    cycle(1'b0, 64'd0, 1'b1);
    cycle(1'b0, 64'd0, 1'b1);
    check64("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check64("rst_if_pc", if_pc, 64'd0);
    check64("rst_if_inst", {32'd0, if_inst}, 64'd0);
    check64("rst_imem_req", {63'd0, imem_bus.imem_req}, 64'd0);

    // Sequential fetch from RESET_PC
    run(12);
    check64("acc0", log_at(1'b0, 0), 64'h400);
    check64("acc1", log_at(1'b0, 1), 64'h404);
    check64("acc2", log_at(1'b0, 2), 64'h408);
    check64("pop0", log_at(1'b1, 0), 64'h400);
    check64("pop1", log_at(1'b1, 1), 64'h404);
    check64("pop2", log_at(1'b1, 2), 64'h408);

    // Decode stall for 10 cycles, then resume
    idr_pct = 0;
    run(10);
    check64("stall_req", {63'd0, imem_bus.imem_req}, 64'd0);
    check64("stall_valid", {63'd0, if_valid}, 64'd1);
    idr_pct = 100;
    run(10);

    // Redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend.size() != 2; k++) run(1);
    check64("wait_two_outstanding", pend.size(), 64'd2);
    cycle(1'b1, 64'h1000, 1'b0);
    n = pop_log.size();
    run(15);
    check64("redir_pop0", log_at(1'b1, n), 64'h1000);
    check64("redir_pop1", log_at(1'b1, n + 1), 64'h1004);

    // Response, pop and redirect in the same cycle
    lat_min = 1; lat_max = 1;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (mq.size() != 0 && pend.size() != 0 && pend[0].due <= cyc) begin
        hit = 1'b1;
        cycle(1'b1, 64'h2000, 1'b0);
      end else begin
        run(1);
      end
    end
    check64("wait_collision", {63'd0, hit}, 64'd1);
    n = pop_log.size();
    run(1);
    check64("collide_valid", {63'd0, if_valid}, 64'd0);
    run(10);
    check64("collide_pop0", log_at(1'b1, n), 64'h2000);

    // PC wraps modulo 2^64
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    n = pop_log.size();
    run(14);
    check64("wrap_pop1", log_at(1'b1, n + 1), 64'hFFFF_FFFF_FFFF_FFFC);
    check64("wrap_pop2", log_at(1'b1, n + 2), 64'h0);
    check64("wrap_pop3", log_at(1'b1, n + 3), 64'h4);

    // Reset with requests in flight
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend.size() == 0; k++) run(1);
    check64("wait_inflight", {63'd0, pend.size() != 0}, 64'd1);
    cycle(1'b0, 64'd0, 1'b1);
    n = pop_log.size();
    run(15);
    check64("post_rst_pop0", log_at(1'b1, n), 64'h400);

    // Random ready, latency and decode back-pressure with occasional redirects
    lat_min = 1; lat_max = 4; rdy_pct = 50; idr_pct = 60;
    for (int i = 0; i < 400; i++) begin
      if (i % 67 == 33) cycle(1'b1, 64'h8000 + 64'(i) * 64'h100, 1'b0);
      else cycle(1'b0, 64'd0, 1'b0);
    end

`ifdef IF_MISALIGN_CHK_EN
    lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 100;
    cycle(1'b1, 64'h1002, 1'b0);
    run(1);
    check64("mis_flag", {63'd0, if_misalign}, 64'd1);
    check64("mis_pc", imem_bus.imem_addr, 64'h1002);
    run(6);
    check64("mis_req_low", {63'd0, imem_bus.imem_req}, 64'd0);
    cycle(1'b0, 64'd0, 1'b1);
    run(6);
    check64("mis_cleared", {63'd0, if_misalign}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
